// File: rtl/shared_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encodings and
// width derivation helpers used by the top and the picker.
package shared_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_HANDOFF = 2'd2;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_picker.sv
// Combinational round-robin select: first eligible index above last_owner,
// wrapping around, with last_owner itself considered last.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    last_owner,
    output logic               any,
    output logic [ID_W-1:0]    pick_id
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    // Walk the search order backwards so the closest candidate is written last.
    always_comb begin
        any     = 1'b0;
        pick_id = '0;
        idx     = 0;
        idx_w   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx   = (int'(last_owner) + i) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (eligible[idx_w]) begin
                any     = 1'b1;
                pick_id = idx_w;
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// N-way round-robin bus arbiter with a one-cycle turnaround between owners
// and a hold-time watchdog that penalises an owner until it drops its request.
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 256,
    parameter int ID_W     = id_width(NUM_REQ),
    parameter int CNT_W    = cnt_width(MAX_HOLD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout_pulse,
    output logic [ID_W-1:0]    timeout_id
);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] penalty_q, penalty_d;
    logic               busy_q, busy_d;
    logic               tpulse_q, tpulse_d;
    logic [ID_W-1:0]    tid_q, tid_d;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_any;
    logic [ID_W-1:0]    pick_id;

    assign eligible = req & ~penalty_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .eligible   (eligible),
        .last_owner (last_owner_q),
        .any        (pick_any),
        .pick_id    (pick_id)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        penalty_d    = penalty_q & req;
        busy_d       = busy_q;
        tpulse_d     = 1'b0;
        tid_d        = tid_q;

        case (state_q)
            ST_IDLE, ST_HANDOFF: begin
                if (pick_any) begin
                    state_d      = ST_GRANT;
                    grant_d      = ONE_HOT0 << pick_id;
                    grant_id_d   = pick_id;
                    last_owner_d = pick_id;
                    hold_cnt_d   = '0;
                    busy_d       = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                end
            end
            ST_GRANT: begin
                // A voluntary drop wins over the watchdog on the same edge.
                if (!req[grant_id_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = ST_HANDOFF;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    if (req[grant_id_q]) begin
                        tpulse_d  = 1'b1;
                        tid_d     = grant_id_q;
                        penalty_d = (penalty_q & req) | grant_q;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            last_owner_q <= ID_W'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
            penalty_q    <= '0;
            busy_q       <= 1'b0;
            tpulse_q     <= 1'b0;
            tid_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            penalty_q    <= penalty_d;
            busy_q       <= busy_d;
            tpulse_q     <= tpulse_d;
            tid_q        <= tid_d;
        end
    end

    assign grant         = grant_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
    assign timeout_pulse = tpulse_q;
    assign timeout_id    = tid_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter with NUM_REQ=4, MAX_HOLD=8.
module tb_shared_bus_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_pulse;
    logic [1:0] timeout_id;

    int total = 0;
    int bad   = 0;

    shared_bus_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse),
        .timeout_id    (timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        tick();
        total++;
        if ({grant, grant_id, busy, timeout_pulse, timeout_id} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs got g=%b id=%0d busy=%b tp=%b tid=%0d want all zero",
                     grant, grant_id, busy, timeout_pulse, timeout_id);
        end
        req = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        tick();
        total++;
        if ({grant, grant_id, busy} !== {4'b0001, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL single_grant got g=%b id=%0d busy=%b want g=0001 id=0 busy=1",
                     grant, grant_id, busy);
        end
        req = 4'b0000;
        tick();
        total++;
        if ({grant, busy} !== {4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL single_handoff got g=%b busy=%b want g=0000 busy=0", grant, busy);
        end
        tick();
        total++;
        if ({grant, grant_id, busy} !== 7'b0) begin
            bad++;
            $display("FAIL single_idle got g=%b id=%0d busy=%b want zero", grant, grant_id, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [3:0] exp_g;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << order[k];
            for (int c = 0; c < 3; c++) begin
                total++;
                if ({grant, grant_id, busy} !== {exp_g, order[k], 1'b1}) begin
                    bad++;
                    $display("FAIL rr_owner k=%0d c=%0d got g=%b id=%0d busy=%b want g=%b id=%0d busy=1",
                             k, c, grant, grant_id, busy, exp_g, order[k]);
                end
                if (c < 2) tick();
            end
            req[order[k]] = 1'b0;
            tick();
            total++;
            if ({grant, busy} !== 5'b0) begin
                bad++;
                $display("FAIL rr_gap k=%0d got g=%b busy=%b want g=0000 busy=0", k, grant, busy);
            end
            req[order[k]] = 1'b1;
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 4'b0100;
        tick();
        for (int c = 0; c < MAX_HOLD; c++) begin
            total++;
            if ({grant, grant_id, timeout_pulse} !== {4'b0100, 2'd2, 1'b0}) begin
                bad++;
                $display("FAIL to_hold c=%0d got g=%b id=%0d tp=%b want g=0100 id=2 tp=0",
                         c, grant, grant_id, timeout_pulse);
            end
            tick();
        end
        total++;
        if ({grant, timeout_pulse, timeout_id} !== {4'b0000, 1'b1, 2'd2}) begin
            bad++;
            $display("FAIL to_fire got g=%b tp=%b tid=%0d want g=0000 tp=1 tid=2",
                     grant, timeout_pulse, timeout_id);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({grant, busy, timeout_pulse, timeout_id} !== {4'b0000, 1'b0, 1'b0, 2'd2}) begin
                bad++;
                $display("FAIL to_penalised c=%0d got g=%b busy=%b tp=%b tid=%0d want g=0000 busy=0 tp=0 tid=2",
                         c, grant, busy, timeout_pulse, timeout_id);
            end
        end
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        total++;
        if ({grant, grant_id} !== {4'b0100, 2'd2}) begin
            bad++;
            $display("FAIL to_regrant got g=%b id=%0d want g=0100 id=2", grant, grant_id);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_release_at_limit();
        apply_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < MAX_HOLD - 1; c++) tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL lim_still_held got g=%b want 0010", grant);
        end
        req = 4'b0000;
        tick();
        total++;
        if ({grant, timeout_pulse, timeout_id} !== {4'b0000, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL lim_normal_release got g=%b tp=%b tid=%0d want g=0000 tp=0 tid=0",
                     grant, timeout_pulse, timeout_id);
        end
        req = 4'b0010;
        tick();
        total++;
        if ({grant, grant_id} !== {4'b0010, 2'd1}) begin
            bad++;
            $display("FAIL lim_no_penalty got g=%b id=%0d want g=0010 id=1", grant, grant_id);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_penalty_pair();
        apply_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < MAX_HOLD; c++) tick();
        total++;
        if ({timeout_pulse, timeout_id} !== {1'b1, 2'd0}) begin
            bad++;
            $display("FAIL pen_timeout got tp=%b tid=%0d want tp=1 tid=0", timeout_pulse, timeout_id);
        end
        req = 4'b0011;
        tick();
        for (int r = 0; r < 3; r++) begin
            total++;
            if ({grant, grant_id} !== {4'b0010, 2'd1}) begin
                bad++;
                $display("FAIL pen_only_one r=%0d got g=%b id=%0d want g=0010 id=1", r, grant, grant_id);
            end
            req = 4'b0001;
            tick();
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL pen_gap r=%0d got g=%b want 0000", r, grant);
            end
            req = 4'b0011;
            tick();
        end
        req = 4'b0010;
        tick();
        req = 4'b0001;
        tick();
        tick();
        total++;
        if ({grant, grant_id} !== {4'b0001, 2'd0}) begin
            bad++;
            $display("FAIL pen_cleared got g=%b id=%0d want g=0001 id=0", grant, grant_id);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        // Runs right after the timeout scenario: last owner 2, timeout_id 2.
        req = 4'b1000;
        tick();
        tick();
        total++;
        if ({grant, grant_id, timeout_id} !== {4'b1000, 2'd3, 2'd2}) begin
            bad++;
            $display("FAIL ar_pre got g=%b id=%0d tid=%0d want g=1000 id=3 tid=2",
                     grant, grant_id, timeout_id);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({grant, grant_id, busy, timeout_pulse, timeout_id} !== 10'b0) begin
            bad++;
            $display("FAIL ar_async got g=%b id=%0d busy=%b tp=%b tid=%0d want all zero",
                     grant, grant_id, busy, timeout_pulse, timeout_id);
        end
        req = 4'b1001;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({grant, grant_id, busy} !== {4'b0001, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL ar_first_owner got g=%b id=%0d busy=%b want g=0001 id=0 busy=1",
                     grant, grant_id, busy);
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_release_at_limit();
        test_penalty_pair();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
